// File: rtl/rom_reader.sv
// rom_reader: burst read sequencer for an asynchronous ROM, returning each word on a valid/ready
// stream. Define ROM_READER_CHECKSUM_EN to add the o_rsp_sum running-sum output.
module rom_reader #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [ADDR_W-1:0] i_req_len,
    input  logic              i_abort,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_last,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_rom_address,
    output logic              o_rom_ce,
    output logic              o_rom_read_en,
    input  logic [DATA_W-1:0] i_rom_data
`ifdef ROM_READER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] o_rsp_sum
`endif
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [3:0] LastWait = 4'(WAIT_CYC - 1);

    state_e            r_state;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [ADDR_W-1:0] r_remaining;
    logic [3:0]        r_wait;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_last;
    logic [ADDR_W-1:0] r_rom_address;
    logic              r_rom_strobe;
`ifdef ROM_READER_CHECKSUM_EN
    logic [DATA_W-1:0] r_rsp_sum;
`endif

    logic              w_handshake;
    logic [ADDR_W-1:0] w_next_addr;

    assign w_handshake = r_rsp_valid & i_rsp_ready;
    assign w_next_addr = r_cur_addr + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_cur_addr    <= '0;
            r_remaining   <= '0;
            r_wait        <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_last    <= 1'b0;
            r_rom_address <= '0;
            r_rom_strobe  <= 1'b0;
`ifdef ROM_READER_CHECKSUM_EN
            r_rsp_sum     <= '0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    // abort is deliberately ignored here; a coincident request still starts
                    if (i_req_valid) begin
                        r_cur_addr    <= i_req_addr;
                        r_remaining   <= i_req_len;
                        r_wait        <= '0;
                        r_rom_address <= i_req_addr;
                        r_rom_strobe  <= 1'b1;
                        r_state       <= StAccess;
`ifdef ROM_READER_CHECKSUM_EN
                        r_rsp_sum     <= '0;
`endif
                    end
                end
                StAccess: begin
                    if (i_abort) begin
                        r_rom_strobe  <= 1'b0;
                        r_rom_address <= '0;
                        r_state       <= StIdle;
                    end else if (r_wait == LastWait) begin
                        r_rsp_data    <= i_rom_data;
                        r_rsp_last    <= (r_remaining == '0);
                        r_rsp_valid   <= 1'b1;
                        r_rom_strobe  <= 1'b0;
                        r_rom_address <= '0;
                        r_state       <= StResp;
`ifdef ROM_READER_CHECKSUM_EN
                        r_rsp_sum     <= r_rsp_sum + i_rom_data;
`endif
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                StResp: begin
                    // A handshake coinciding with abort still delivers that word
                    if (i_abort || (w_handshake && r_remaining == '0)) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= StIdle;
                    end else if (w_handshake) begin
                        r_rsp_valid   <= 1'b0;
                        r_cur_addr    <= w_next_addr;
                        r_remaining   <= r_remaining - ADDR_W'(1);
                        r_wait        <= '0;
                        r_rom_address <= w_next_addr;
                        r_rom_strobe  <= 1'b1;
                        r_state       <= StAccess;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // req_ready is forced low while reset is asserted, high in IDLE afterwards
    assign o_req_ready   = (r_state == StIdle) & rst_n;
    assign o_busy        = (r_state != StIdle);
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_data    = r_rsp_data;
    assign o_rsp_last    = r_rsp_last;
    assign o_rom_address = r_rom_address;
    assign o_rom_ce      = r_rom_strobe;
    assign o_rom_read_en = r_rom_strobe;
`ifdef ROM_READER_CHECKSUM_EN
    assign o_rsp_sum     = r_rsp_sum;
`endif

endmodule

// File: tb/tb_rom_reader.sv
// Bench for rom_reader: two instances (WAIT_CYC=1 and 3) against a behavioural ROM, with a
// scoreboard of expected beats per instance.
module tb_rom_reader;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [7:0] sum;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] mem [256];
    int         n_vec;
    int         n_err;
    int         cyc;

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1;
    exp_t e3;
    int   n_beats1;
    int   prev_cyc1;
    bit   have_prev1;
    bit   spacing_en;

    logic       req_valid1, req_ready1, abort1, rsp_valid1, rsp_ready1, rsp_last1, busy1;
    logic       ce1, re1;
    logic [7:0] req_addr1, req_len1, rsp_data1, addr1, rom_data1;
    logic       req_valid3, req_ready3, abort3, rsp_valid3, rsp_ready3, rsp_last3, busy3;
    logic       ce3, re3;
    logic [7:0] req_addr3, req_len3, rsp_data3, addr3, rom_data3;
`ifdef ROM_READER_CHECKSUM_EN
    logic [7:0] rsp_sum1, rsp_sum3;
`endif

    assign rom_data1 = ce1 ? mem[addr1] : 8'hEE;
    assign rom_data3 = ce3 ? mem[addr3] : 8'hEE;

    rom_reader #(.ADDR_W(8), .DATA_W(8), .WAIT_CYC(1)) u_dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_valid   (req_valid1),
        .o_req_ready   (req_ready1),
        .i_req_addr    (req_addr1),
        .i_req_len     (req_len1),
        .i_abort       (abort1),
        .o_rsp_valid   (rsp_valid1),
        .i_rsp_ready   (rsp_ready1),
        .o_rsp_data    (rsp_data1),
        .o_rsp_last    (rsp_last1),
        .o_busy        (busy1),
        .o_rom_address (addr1),
        .o_rom_ce      (ce1),
        .o_rom_read_en (re1),
        .i_rom_data    (rom_data1)
`ifdef ROM_READER_CHECKSUM_EN
        , .o_rsp_sum   (rsp_sum1)
`endif
    );

    rom_reader #(.ADDR_W(8), .DATA_W(8), .WAIT_CYC(3)) u_dut3 (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_valid   (req_valid3),
        .o_req_ready   (req_ready3),
        .i_req_addr    (req_addr3),
        .i_req_len     (req_len3),
        .i_abort       (abort3),
        .o_rsp_valid   (rsp_valid3),
        .i_rsp_ready   (rsp_ready3),
        .o_rsp_data    (rsp_data3),
        .o_rsp_last    (rsp_last3),
        .o_busy        (busy3),
        .o_rom_address (addr3),
        .o_rom_ce      (ce3),
        .o_rom_read_en (re3),
        .i_rom_data    (rom_data3)
`ifdef ROM_READER_CHECKSUM_EN
        , .o_rsp_sum   (rsp_sum3)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Response monitors: a handshake seen at the falling edge completes on the next rising edge
    always @(negedge clk) begin
        if (rst_n && rsp_valid1 && rsp_ready1) begin
            if (q1.size() == 0) begin
                chk("rsp1_unexpected", 32'(rsp_valid1), 32'd0);
            end else begin
                e1 = q1.pop_front();
                chk("rsp1_data", 32'(rsp_data1), 32'(e1.data));
                chk("rsp1_last", 32'(rsp_last1), 32'(e1.last));
`ifdef ROM_READER_CHECKSUM_EN
                chk("rsp1_sum", 32'(rsp_sum1), 32'(e1.sum));
`endif
                if (spacing_en && have_prev1) chk("beat_spacing", 32'(cyc - prev_cyc1), 32'd2);
                prev_cyc1  = cyc;
                have_prev1 = !e1.last;
                n_beats1++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rsp_valid3 && rsp_ready3) begin
            if (q3.size() == 0) begin
                chk("rsp3_unexpected", 32'(rsp_valid3), 32'd0);
            end else begin
                e3 = q3.pop_front();
                chk("rsp3_data", 32'(rsp_data3), 32'(e3.data));
                chk("rsp3_last", 32'(rsp_last3), 32'(e3.last));
`ifdef ROM_READER_CHECKSUM_EN
                chk("rsp3_sum", 32'(rsp_sum3), 32'(e3.sum));
`endif
            end
        end
    end

    // Pushes n_push expected beats, then holds the request for one accepting edge
    task automatic request(input bit sel3, input logic [7:0] addr, input logic [7:0] len,
                           input int n_push);
        exp_t       e;
        logic [7:0] s;
        logic [7:0] a;
        int         n;
        s = 8'h00;
        for (int k = 0; k < n_push; k++) begin
            a      = addr + 8'(k);
            s      = s + mem[a];
            e.data = mem[a];
            e.last = (k == int'(len));
            e.sum  = s;
            if (sel3) q3.push_back(e);
            else q1.push_back(e);
        end
        n = 0;
        while (!(sel3 ? req_ready3 : req_ready1) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 50) chk("req_ready_timeout", 32'(sel3 ? req_ready3 : req_ready1), 32'd1);
        if (sel3) begin
            req_valid3 = 1'b1; req_addr3 = addr; req_len3 = len;
        end else begin
            req_valid1 = 1'b1; req_addr1 = addr; req_len1 = len;
        end
        @(posedge clk);
        #1;
        req_valid1 = 1'b0;
        req_valid3 = 1'b0;
    endtask

    task automatic drain(input bit sel3);
        int n;
        n = 0;
        while (((sel3 ? q3.size() : q1.size()) != 0 || (sel3 ? busy3 : busy1)) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(sel3 ? "drain3_queue" : "drain1_queue", 32'(sel3 ? q3.size() : q1.size()), 32'd0);
        chk(sel3 ? "drain3_busy" : "drain1_busy", 32'(sel3 ? busy3 : busy1), 32'd0);
    endtask

    initial begin
        int n;
        int base;
        n_vec = 0; n_err = 0; cyc = 0; n_beats1 = 0; prev_cyc1 = 0;
        have_prev1 = 1'b0; spacing_en = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        rst_n = 1'b0;
        req_valid1 = 0; req_addr1 = 0; req_len1 = 0; abort1 = 0; rsp_ready1 = 0;
        req_valid3 = 0; req_addr3 = 0; req_len3 = 0; abort3 = 0; rsp_ready3 = 0;

        // Reset values
        #12;
        chk("rst_req_ready", 32'(req_ready1), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_ce", 32'(ce1), 32'd0);
        chk("rst_addr", 32'(addr1), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_req_ready", 32'(req_ready1), 32'd1);

        // Single read
        mem[8'h10] = 8'hA5;
        rsp_ready1 = 1'b1;
        request(1'b0, 8'h10, 8'h00, 1);
        chk("t1_ce", 32'(ce1), 32'd1);
        chk("t1_read_en", 32'(re1), 32'd1);
        chk("t1_addr", 32'(addr1), 32'h10);
        chk("t1_req_ready_busy", 32'(req_ready1), 32'd0);
        @(posedge clk);
        #1;
        chk("t1_ce_one_cycle", 32'(ce1), 32'd0);
        chk("t1_addr_parked", 32'(addr1), 32'd0);
        chk("t1_rsp_valid", 32'(rsp_valid1), 32'd1);
        chk("t1_rsp_data", 32'(rsp_data1), 32'hA5);
        chk("t1_rsp_last", 32'(rsp_last1), 32'd1);
        @(posedge clk);
        #1;
        chk("t1_idle_ready", 32'(req_ready1), 32'd1);
        chk("t1_idle_busy", 32'(busy1), 32'd0);
        chk("t1_idle_valid", 32'(rsp_valid1), 32'd0);
        mem[8'h10] = 8'h10;

        // Full sweep with beat spacing
        spacing_en = 1'b1;
        base = n_beats1;
        request(1'b0, 8'h00, 8'hFF, 256);
        drain(1'b0);
        chk("t2_beats", 32'(n_beats1 - base), 32'd256);
        spacing_en = 1'b0;

        // Wrap-around
        base = n_beats1;
        request(1'b0, 8'hFE, 8'h03, 4);
        drain(1'b0);
        chk("t3_beats", 32'(n_beats1 - base), 32'd4);

        // Backpressure on the WAIT_CYC=3 instance
        request(1'b1, 8'h40, 8'h01, 2);
        n = 0;
        while (ce3 && n < 10) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("t4_ce_cycles_b0", 32'(n), 32'd3);
        for (int i = 0; i < 5; i++) begin
            chk("t4_stall_valid", 32'(rsp_valid3), 32'd1);
            chk("t4_stall_data", 32'(rsp_data3), 32'h40);
            chk("t4_stall_ce", 32'(ce3), 32'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready3 = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        while (ce3 && n < 10) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("t4_ce_cycles_b1", 32'(n), 32'd3);
        drain(1'b1);

        // Abort during ACCESS of beat 2
        base = n_beats1;
        request(1'b0, 8'h20, 8'h07, 2);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_in_access_b2", 32'(ce1), 32'd1);
        chk("t5_addr_b2", 32'(addr1), 32'h22);
        abort1 = 1'b1;
        @(posedge clk);
        #1;
        abort1 = 1'b0;
        chk("t5_ce_dropped", 32'(ce1), 32'd0);
        chk("t5_read_en_dropped", 32'(re1), 32'd0);
        chk("t5_busy", 32'(busy1), 32'd0);
        chk("t5_rsp_valid", 32'(rsp_valid1), 32'd0);
        chk("t5_beats", 32'(n_beats1 - base), 32'd2);
        request(1'b0, 8'h30, 8'h00, 1);
        chk("t5_new_req_ce", 32'(ce1), 32'd1);
        chk("t5_new_req_addr", 32'(addr1), 32'h30);
        drain(1'b0);

        // Asynchronous reset while in RESP
        rsp_ready1 = 1'b0;
        request(1'b0, 8'h50, 8'h01, 0);
        @(posedge clk);
        #1;
        chk("t6_in_resp", 32'(rsp_valid1), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(rsp_valid1), 32'd0);
        chk("t6_data", 32'(rsp_data1), 32'd0);
        chk("t6_last", 32'(rsp_last1), 32'd0);
        chk("t6_busy", 32'(busy1), 32'd0);
        chk("t6_req_ready", 32'(req_ready1), 32'd0);
        chk("t6_ce", 32'(ce1), 32'd0);
        chk("t6_read_en", 32'(re1), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_post_ready", 32'(req_ready1), 32'd1);
        chk("t6_post_busy", 32'(busy1), 32'd0);
        rsp_ready1 = 1'b1;
        request(1'b0, 8'h60, 8'h00, 1);
        drain(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
